// File: rtl/trinity_pkg.sv
// Shared definitions for the multi-channel ternary mutation sequencer:
// trit encodings, FSM states, LFSR taps and seed helpers.
package trinity_pkg;

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_t;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [31:0] SEED_SPREAD = 32'h9E37_79B9;

    // Per-channel seed; an all-zero LFSR would lock up, so map it to 1.
    function automatic logic [31:0] derive_seed(input logic [31:0] base, input int unsigned ch);
        logic [31:0] s;
        s = base ^ (ch * SEED_SPREAD);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic logic [31:0] lfsr_advance(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'd0);
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {12'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/trinity_lfsr_trit.sv
// One mutation channel: Galois LFSR with reseed/step control and a
// threshold compare that turns the next LFSR value into a trit.
module trinity_lfsr_trit
    import trinity_pkg::*;
#(
    parameter int unsigned   CH_IDX   = 0,
    parameter int            LFSR_W   = 32,
    parameter int            THRESH_W = 16,
    parameter logic [LFSR_W-1:0] DEF_SEED = 32'hACE1_1234
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [LFSR_W-1:0]   seed_base,
    input  logic [THRESH_W-1:0] threshold,
    output logic [1:0]          trit_next
);

    logic [LFSR_W-1:0] lfsr_reg;
    logic [LFSR_W-1:0] lfsr_next;

    assign lfsr_next = lfsr_advance(lfsr_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= derive_seed(DEF_SEED, CH_IDX);
        end else if (load) begin
            lfsr_reg <= derive_seed(seed_base, CH_IDX);
        end else if (step) begin
            lfsr_reg <= lfsr_next;
        end
    end

    // The trit is taken from the value the LFSR is about to hold, so the
    // registered word and the LFSR state move together.
    always_comb begin
        trit_next = TRIT_ZERO;
        if (lfsr_next[THRESH_W-1:0] < threshold) begin
            trit_next = lfsr_next[LFSR_W-1] ? TRIT_NEG : TRIT_POS;
        end
    end

endmodule

// File: rtl/trinity_mutation_sequencer_mc.sv
// Multi-channel ternary mutation sequencer with a valid/ready output stream.
// Define TRINITY_SEQ_SIGN_STATS_EN to add the pos_count/neg_count outputs.
module trinity_mutation_sequencer_mc
    import trinity_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int LFSR_W     = 32,
    parameter int THRESH_W   = 16,
    parameter int DEF_THRESH = 2490,
    parameter logic [LFSR_W-1:0] DEF_SEED = 32'hACE1_1234
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  cfg_load,
    input  logic [THRESH_W-1:0]   cfg_threshold,
    input  logic [LFSR_W-1:0]     cfg_seed,
    input  logic                  stat_clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NUM_CH-1:0]   mutation_trits,
    output logic [15:0]           mut_count,
    output logic                  busy
`ifdef TRINITY_SEQ_SIGN_STATS_EN
    ,
    output logic [15:0]           pos_count,
    output logic [15:0]           neg_count
`endif
);

    seq_state_t state_reg, state_next;
    logic load_now, run_now, step, handshake;

    logic [THRESH_W-1:0] thresh_reg;
    logic                out_valid_reg;
    logic [2*NUM_CH-1:0] trits_reg;
    logic [2*NUM_CH-1:0] word_next;
    logic [15:0]         mut_count_reg;
    logic [4:0]          pop_all;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_load) begin
                    state_next = ST_LOAD;
                end else if (enable) begin
                    state_next = ST_RUN;
                end
            end
            ST_LOAD: state_next = enable ? ST_RUN : ST_IDLE;
            ST_RUN:  if (!enable) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        load_now = (state_reg == ST_LOAD);
        run_now  = (state_reg == ST_RUN);
        busy     = load_now || run_now;
    end

    assign handshake = out_valid_reg && out_ready;
    assign step      = run_now && (!out_valid_reg || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_reg <= THRESH_W'(DEF_THRESH);
        end else if (load_now) begin
            thresh_reg <= cfg_threshold;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            trinity_lfsr_trit #(
                .CH_IDX   (gi),
                .LFSR_W   (LFSR_W),
                .THRESH_W (THRESH_W),
                .DEF_SEED (DEF_SEED)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .load      (load_now),
                .step      (step),
                .seed_base (cfg_seed),
                .threshold (thresh_reg),
                .trit_next (word_next[2*gi +: 2])
            );
        end
    endgenerate

    // A word generated while the previous one is accepted replaces it in
    // place; otherwise an accepted word simply retires the valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            trits_reg     <= '0;
        end else if (step) begin
            out_valid_reg <= 1'b1;
            trits_reg     <= word_next;
        end else if (handshake) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid      = out_valid_reg;
    assign mutation_trits = trits_reg;

    always_comb begin
        pop_all = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop_all = pop_all + {4'd0, (trits_reg[2*i +: 2] != TRIT_ZERO)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mut_count_reg <= '0;
        end else if (stat_clear) begin
            mut_count_reg <= '0;
        end else if (handshake) begin
            mut_count_reg <= sat_add16(mut_count_reg, pop_all);
        end
    end

    assign mut_count = mut_count_reg;

`ifdef TRINITY_SEQ_SIGN_STATS_EN
    logic [4:0]  pop_pos, pop_neg;
    logic [15:0] pos_count_reg, neg_count_reg;

    always_comb begin
        pop_pos = '0;
        pop_neg = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop_pos = pop_pos + {4'd0, (trits_reg[2*i +: 2] == TRIT_POS)};
            pop_neg = pop_neg + {4'd0, (trits_reg[2*i +: 2] == TRIT_NEG)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_count_reg <= '0;
            neg_count_reg <= '0;
        end else if (stat_clear) begin
            pos_count_reg <= '0;
            neg_count_reg <= '0;
        end else if (handshake) begin
            pos_count_reg <= sat_add16(pos_count_reg, pop_pos);
            neg_count_reg <= sat_add16(neg_count_reg, pop_neg);
        end
    end

    assign pos_count = pos_count_reg;
    assign neg_count = neg_count_reg;
`endif

endmodule
